// File: rtl/miner_pkg.sv
// Shared types and constants for the bitcoin miner.
// Scheduler state plus the SHA-256 IV and round constants used by the hash core.
package miner_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sched_state_e;

    localparam logic [31:0] SHA_IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] SHA_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
// Shared by the result write path and the planned memory read path.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    always_comb begin : search
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any && req[idx[IW-1:0]]) begin
                any                = 1'b1;
                gnt[idx[IW-1:0]]   = 1'b1;
                gnt_idx            = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/nonce_scheduler.sv
// Nonce scheduler: hands nonces to idle hash cores, holds their H0
// results and streams them to memory through the single write port.
module nonce_scheduler
    import miner_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int NUM_NONCES = 16,
    parameter int ADDR_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       output_addr,
    output logic                    done,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [NUM_CORES*32-1:0] core_nonce,
    input  logic [NUM_CORES-1:0]    core_done,
    input  logic [NUM_CORES*32-1:0] core_hash,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [31:0]             mem_write_data
);

    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [16:0] NONCE_END = 17'(NUM_NONCES);
    localparam logic [IW-1:0] LAST = IW'(NUM_CORES - 1);

    sched_state_e         state;
    logic [ADDR_W-1:0]    base;
    logic [16:0]          next_nonce;
    logic [16:0]          wr_count;
    logic [NUM_CORES-1:0] busy;
    logic [NUM_CORES-1:0] held;
    logic [NUM_CORES-1:0] cap;
    logic [NUM_CORES-1:0] gnt;
    logic [NUM_CORES-1:0] disp_oh;
    logic [31:0]          nonce_q [NUM_CORES];
    logic [31:0]          hash_q [NUM_CORES];
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        gnt_idx;
    logic [IW-1:0]        disp_idx;
    logic                 any;
    logic                 disp_ok;

    // Late results from a core that is not busy (e.g. after reset) drop here.
    assign cap = core_done & busy;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        assign core_nonce[i*32 +: 32] = nonce_q[i];
    end

    rr_arbiter #(
        .N  (NUM_CORES),
        .IW (IW)
    ) u_arb (
        .req     (held),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_comb begin
        disp_oh  = '0;
        disp_idx = '0;
        disp_ok  = 1'b0;
        if (state == RUN && next_nonce < NONCE_END) begin
            for (int i = NUM_CORES - 1; i >= 0; i--) begin
                if (!busy[i] && !held[i]) begin
                    disp_ok  = 1'b1;
                    disp_idx = IW'(i);
                end
            end
            if (disp_ok) begin
                disp_oh[disp_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            done           <= 1'b0;
            core_start     <= '0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            base           <= '0;
            next_nonce     <= '0;
            wr_count       <= '0;
            busy           <= '0;
            held           <= '0;
            ptr            <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                nonce_q[i] <= '0;
                hash_q[i]  <= '0;
            end
        end else begin
            core_start <= '0;
            mem_we     <= 1'b0;
            busy       <= (busy & ~cap) | disp_oh;
            held       <= (held & ~gnt) | cap;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (cap[i]) begin
                    hash_q[i] <= core_hash[i*32 +: 32];
                end
            end
            if (disp_ok) begin
                core_start          <= disp_oh;
                nonce_q[disp_idx]   <= 32'(next_nonce);
                next_nonce          <= next_nonce + 17'd1;
            end
            if (any) begin
                mem_we         <= 1'b1;
                mem_addr       <= base + nonce_q[gnt_idx][ADDR_W-1:0];
                mem_write_data <= hash_q[gnt_idx];
                ptr            <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
                wr_count       <= wr_count + 17'd1;
            end
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        base       <= output_addr;
                        next_nonce <= '0;
                        wr_count   <= '0;
                        done       <= 1'b0;
                    end
                end
                RUN: begin
                    if (wr_count == NONCE_END) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
